seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (legal 2..16).
REQ-002 Parameter CNT_W, default 16, width of match counter.
REQ-003 Parameter RST_PAT, default 8'b0000_1001, pattern loaded at reset.
REQ-004 Parameter RST_LEN, default 4, pattern length loaded at reset.
REQ-005 Parameter RST_OVL, default 1, overlap mode loaded at reset.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  sample `in` on this edge when high.
REQ-009 in  in  1  serial data bit.
REQ-010 cfg_load  in  1  load cfg_pat/cfg_len/cfg_ovl and clear history.
REQ-011 cfg_pat  in  PAT_W  pattern; cfg_pat[len-1] is first bit received, cfg_pat[0] is last.
REQ-012 cfg_len  in  LEN_W (= clog2(PAT_W+1))  active pattern length.
REQ-013 cfg_ovl  in  1  1 = overlapping matches allowed.
REQ-014 out  out  1  one-cycle match pulse, registered.
REQ-015 match_cnt  out  CNT_W  total matches since reset/cfg_load, saturating.
REQ-016 fill  out  LEN_W  valid history bits collected, saturates at active length.

Function
REQ-017 Block SHALL keep a PAT_W-bit history shift register; on en=1, history <= {history[PAT_W-2:0], in}.
REQ-018 fill SHALL increment by 1 per sampled bit, saturating at active length.
REQ-019 Match condition SHALL be: en=1, fill (after increment) == len, and history[len-1:0] (after shift) == pat[len-1:0].
REQ-020 On a match edge, out SHALL be 1 for exactly the following cycle; otherwise out SHALL be 0.
REQ-021 On a match edge, match_cnt SHALL increment by 1, holding at 2^CNT_W-1 without wrap.
REQ-022 Overlap mode (ovl=1): after a match, fill SHALL stay at len, so a match can recur on the next bit.
REQ-023 Non-overlap mode (ovl=0): after a match, fill SHALL clear to 0; the next match needs len fresh bits.
REQ-024 en=0 SHALL hold history, fill, match_cnt; out SHALL be 0.
REQ-025 cfg_load=1 SHALL load pat/len/ovl, clear history, fill, match_cnt, out; a coincident en bit SHALL be discarded.
REQ-026 cfg_len > PAT_W SHALL be clamped to PAT_W at load; cfg_len = 0 SHALL disable matching (out stays 0, fill stays 0).
REQ-027 Bits above len in history SHALL never affect the match result.
REQ-028 Control FSM SHALL have states FILLING (fill<len), ARMED (fill==len), DISABLED (len==0); transitions: FILLING->ARMED when fill reaches len, ARMED->FILLING on non-overlap match, any->FILLING/DISABLED on cfg_load per new len.

Reset
REQ-029 Asserting reset (low) SHALL immediately set history=0, fill=0, out=0, match_cnt=0, pat=RST_PAT, len=RST_LEN, ovl=RST_OVL.
REQ-030 Reset mid-stream SHALL discard partial history; first match after release needs len fresh bits.
REQ-031 Reset release SHALL be synchronised by the instantiating level; the block samples on the first rising edge after deassertion.

Structure
REQ-032 Shared package seq_pkg SHALL hold the LEN_W width function, state enumeration (FILLING/ARMED/DISABLED), and default constants.
REQ-033 History register plus masked comparator SHALL be one sub-module, seq_det_hist; control FSM, fill and counter stay in seq_det_param.

Verification
REQ-034 Reset defaults (1001, len 4, ovl 1), stream 1,0,0,1,0,0,1 with en=1 -> out pulses after bits 4 and 7, match_cnt=2.
REQ-035 cfg_load pat=1001 len=4 ovl=0, same stream -> out pulse after bit 4 only, match_cnt=1, fill=3 at end.
REQ-036 PAT_W=8, cfg_load pat=8'b1100_1001 len=8, stream 1100_1001 with en gaps of 3 cycles -> single pulse after 8th sampled bit, fill=8.
REQ-037 Reset asserted after 3 of 4 pattern bits, released, last bit sent -> no pulse; full 1001 then sent -> one pulse, match_cnt=1.
REQ-038 CNT_W=2, overlap pattern 11 len 2, stream of 6 ones -> 5 pulses, match_cnt saturates at 3.
REQ-039 cfg_load with cfg_len=0, then 10 random bits -> out never asserts, fill=0; cfg_len=12 with PAT_W=8 -> len reads back as 8.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared widths, control states and reset defaults for the sequence detector
// Provides len_w() (width needed to hold a length 0..PAT_W), state_t and DEF_* constants.
package seq_pkg;
    typedef enum logic [1:0] {FILLING, ARMED, DISABLED} state_t;
    localparam int DEF_PAT_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_RST_PAT = 9;
    localparam int DEF_RST_LEN = 4;
    localparam bit DEF_RST_OVL = 1'b1;
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction
endpackage

// File: rtl/seq_det_param_if.sv
// seq_det_param_if: stream, configuration and status bundle for seq_det_param
// master drives en, in, cfg_load, cfg_pat, cfg_len, cfg_ovl; slave drives out, match_cnt, fill.
interface seq_det_param_if import seq_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int LEN_W = len_w(PAT_W);
    logic             en;
    logic             in;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic [LEN_W-1:0] fill;
    modport master (output en, in, cfg_load, cfg_pat, cfg_len, cfg_ovl, input out, match_cnt, fill);
    modport slave (input en, in, cfg_load, cfg_pat, cfg_len, cfg_ovl, output out, match_cnt, fill);
endinterface

// File: rtl/seq_det_hist.sv
// seq_det_hist: history shift register with a length-masked pattern comparator
// Ports: clk, reset (async active-low), clr (sync clear), shift (take bit_in),
//        bit_in, pat/len (active pattern), hit (history after this shift equals pattern).
module seq_det_hist import seq_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);
    logic [PAT_W-1:0] hist, nxt, mask;
    assign nxt  = {hist[PAT_W-2:0], bit_in};
    // only the newest len bits take part, so older history can never cause or block a match
    assign mask = ~({PAT_W{1'b1}} << len);
    assign hit  = ((nxt ^ pat) & mask) == '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) hist <= '0;
        else if (clr) hist <= '0;
        else if (shift) hist <= nxt;
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: programmable serial pattern detector with overlap control and match counter
// Ports: clk, reset (async active-low), bus (slave: en/in stream, cfg_* load, out/match_cnt/fill status).
module seq_det_param import seq_pkg::*; #(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               RST_LEN = DEF_RST_LEN,
    parameter bit               RST_OVL = DEF_RST_OVL
) (
    input logic            clk,
    input logic            reset,
    seq_det_param_if.slave bus
);
    localparam int LEN_W = len_w(PAT_W);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] INIT_LEN = LEN_W'(RST_LEN);
    state_t state, state_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic [LEN_W-1:0] len, len_n, fill, fill_n, new_len;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic ovl, ovl_n, out, out_n, hit;
    assign new_len       = bus.cfg_len > MAX_LEN ? MAX_LEN : bus.cfg_len;
    assign bus.out       = out;
    assign bus.match_cnt = cnt;
    assign bus.fill      = fill;
    seq_det_hist #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_hist (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus.cfg_load),
        .shift  (bus.en & ~bus.cfg_load),
        .bit_in (bus.in),
        .pat    (pat),
        .len    (len),
        .hit    (hit)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= INIT_LEN == '0 ? DISABLED : FILLING;
            pat   <= RST_PAT;
            len   <= INIT_LEN;
            ovl   <= RST_OVL;
            fill  <= '0;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            len   <= len_n;
            ovl   <= ovl_n;
            fill  <= fill_n;
            cnt   <= cnt_n;
            out   <= out_n;
        end
    always_comb begin
        state_n = state;
        pat_n   = pat;
        len_n   = len;
        ovl_n   = ovl;
        fill_n  = fill;
        cnt_n   = cnt;
        out_n   = 1'b0;
        if (bus.cfg_load) begin
            pat_n   = bus.cfg_pat;
            len_n   = new_len;
            ovl_n   = bus.cfg_ovl;
            fill_n  = '0;
            cnt_n   = '0;
            state_n = new_len == '0 ? DISABLED : FILLING;
        end else if (bus.en && state != DISABLED) begin
            fill_n = state == ARMED ? fill : fill + 1'b1;
            out_n  = fill_n == len && hit;
            cnt_n  = out_n && !(&cnt) ? cnt + 1'b1 : cnt;
            // a non-overlapping match consumes its bits, so collection restarts from zero
            fill_n  = out_n && !ovl ? '0 : fill_n;
            state_n = fill_n == len ? ARMED : FILLING;
        end
    end
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed table and sequence checks for seq_det_param
module tb_seq_det_param;
    import seq_pkg::*;
    typedef struct {
        logic       en;
        logic       in;
        logic       load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        int         out;
        int         cnt;
        int         fill;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pulses;
    vec_t vecs[$];
    logic [7:0] p8;
    always #5 clk = ~clk;
    seq_det_param_if #(.PAT_W(8), .CNT_W(16)) a ();
    seq_det_param_if #(.PAT_W(8), .CNT_W(2)) b ();
    seq_det_param #(.PAT_W(8), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a));
    seq_det_param #(.PAT_W(8), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(b));
    function automatic vec_t v(input logic en, input logic in, input logic load, input logic [7:0] pat,
                               input logic [3:0] len, input logic ovl, input int out, input int cnt, input int fill);
        vec_t r;
        r.en = en; r.in = in; r.load = load; r.pat = pat; r.len = len; r.ovl = ovl;
        r.out = out; r.cnt = cnt; r.fill = fill;
        return r;
    endfunction
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic set_a(input logic en, input logic in, input logic load, input logic [7:0] pat,
                         input logic [3:0] len, input logic ovl);
        a.en = en; a.in = in; a.cfg_load = load; a.cfg_pat = pat; a.cfg_len = len; a.cfg_ovl = ovl;
    endtask
    task automatic set_b(input logic en, input logic in, input logic load, input logic [7:0] pat,
                         input logic [3:0] len, input logic ovl);
        b.en = en; b.in = in; b.cfg_load = load; b.cfg_pat = pat; b.cfg_len = len; b.cfg_ovl = ovl;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        set_a(0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0);
        // default pattern 1001 len 4 overlapping, then reload as non-overlapping
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1, 4));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 2, 4));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 2, 4));
        vecs.push_back(v(1, 1, 1, 8'h09, 4, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 2));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 1, 3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3));
        step();
        step();
        check("reset out", a.out, 0);
        check("reset cnt", a.match_cnt, 0);
        check("reset fill", a.fill, 0);
        check("reset b cnt", b.match_cnt, 0);
        reset = 1'b1;
        foreach (vecs[i]) begin
            set_a(vecs[i].en, vecs[i].in, vecs[i].load, vecs[i].pat, vecs[i].len, vecs[i].ovl);
            step();
            check($sformatf("vec%0d out", i), a.out, vecs[i].out);
            check($sformatf("vec%0d cnt", i), a.match_cnt, vecs[i].cnt);
            check($sformatf("vec%0d fill", i), a.fill, vecs[i].fill);
        end
        // full-width pattern with idle gaps between sampled bits
        p8 = 8'b1100_1001;
        set_a(0, 0, 1, p8, 8, 1);
        step();
        check("w8 load fill", a.fill, 0);
        for (int i = 0; i < 8; i++) begin
            set_a(1, p8[7-i], 0, 0, 0, 0);
            step();
            check($sformatf("w8 bit%0d out", i), a.out, int'(i == 7));
            check($sformatf("w8 bit%0d fill", i), a.fill, i + 1);
            set_a(0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                step();
                check($sformatf("w8 gap%0d out", i), a.out, 0);
            end
        end
        check("w8 cnt", a.match_cnt, 1);
        check("w8 fill end", a.fill, 8);
        // zero length disables matching
        set_a(0, 0, 1, 8'h09, 0, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            set_a(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
            step();
            check($sformatf("len0 bit%0d out", i), a.out, 0);
            check($sformatf("len0 bit%0d fill", i), a.fill, 0);
        end
        // oversize length clamps to PAT_W
        set_a(0, 0, 1, 8'hFF, 12, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            set_a(1, 1, 0, 0, 0, 0);
            step();
            check($sformatf("clamp bit%0d out", i), a.out, int'(i >= 7));
            check($sformatf("clamp bit%0d fill", i), a.fill, i < 8 ? i + 1 : 8);
        end
        check("clamp cnt", a.match_cnt, 3);
        // asynchronous reset mid-stream discards partial history
        set_a(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("async rst fill", a.fill, 0);
        check("async rst cnt", a.match_cnt, 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_a(1, int'(i == 0), 0, 0, 0, 0);
            step();
            check($sformatf("rst pre bit%0d fill", i), a.fill, i + 1);
        end
        set_a(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("mid rst fill", a.fill, 0);
        step();
        reset = 1'b1;
        set_a(1, 1, 0, 0, 0, 0);
        step();
        check("rst last bit out", a.out, 0);
        check("rst last bit fill", a.fill, 1);
        p8 = 8'b0000_1001;
        pulses = 0;
        for (int i = 3; i >= 0; i--) begin
            set_a(1, p8[i], 0, 0, 0, 0);
            step();
            pulses += int'(a.out);
        end
        check("rst last out", a.out, 1);
        check("rst pulses", pulses, 1);
        check("rst cnt", a.match_cnt, 1);
        set_a(0, 0, 0, 0, 0, 0);
        // counter saturation on a 2-bit counter
        set_b(0, 0, 1, 8'b0000_0011, 2, 1);
        step();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            set_b(1, 1, 0, 0, 0, 0);
            step();
            pulses += int'(b.out);
            check($sformatf("sat bit%0d out", i), b.out, int'(i >= 1));
            check($sformatf("sat bit%0d cnt", i), b.match_cnt, i < 3 ? i : 3);
        end
        check("sat pulses", pulses, 5);
        set_b(0, 0, 0, 0, 0, 0);
        step();
        check("sat hold out", b.out, 0);
        check("sat hold cnt", b.match_cnt, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
